// File: rtl/mem_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_step_sequencer_if
// Brief    : Single-port memory req/ack bus between the sequencer and memory.
// Revision : 1.0
// ============================================================================
interface mem_step_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_step_sequencer
// Brief    : Fetch / optional data access / commit sequencer for a single-cycle
//            core sharing one variable-latency memory port, with watchdog.
// Revision : 1.0
// ============================================================================
module mem_step_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  wire logic              sys_clk,
    input  wire logic              sys_reset,
    input  wire logic              run,
    input  wire logic [ADDR_W-1:0] progctr,
    input  wire logic [ADDR_W-1:0] memory_address,
    input  wire logic [DATA_W-1:0] to_memory,
    input  wire logic              memload_flag,
    input  wire logic              memstore_flag,
    output logic      [DATA_W-1:0] instruction,
    output logic      [DATA_W-1:0] from_memory,
    output logic                   cpu_step,
    output logic                   fault,
    output logic                   busy,
    mem_step_sequencer_if.master   mem
);

    localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_DATA   = 3'd3,
        S_STEP   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] from_q, from_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wait_limit;
    logic [CNT_W-1:0]  cnt_inc;

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q <= S_IDLE;
            instr_q <= NOP_INSTR;
            from_q  <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            from_q  <= from_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ack at the limit cycle is checked before the limit, so a late ack still wins.
    assign wait_limit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        from_d        = from_q;
        fault_d       = fault_q;
        cnt_d         = cnt_q;
        cpu_step      = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = progctr;
                if (mem.mem_ack) begin
                    instr_d = mem.mem_rdata;
                    state_d = S_DECODE;
                end else if (wait_limit) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DECODE: begin
                if (memload_flag || memstore_flag) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_DATA: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = memstore_flag;
                mem.mem_addr  = memory_address;
                mem.mem_wdata = to_memory;
                if (mem.mem_ack) begin
                    // A simultaneous load+store decode is a store: no load data captured.
                    if (memload_flag && !memstore_flag) begin
                        from_d = mem.mem_rdata;
                    end
                    state_d = S_STEP;
                end else if (wait_limit) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_STEP: begin
                cpu_step = 1'b1;
                if (run) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign instruction = instr_q;
    assign from_memory = from_q;
    assign fault       = fault_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_mem_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_step_sequencer
// Brief    : Self-checking bench; acts as core and memory, checks each
//            instruction against a transaction-level latency/data model.
// Revision : 1.0
// ============================================================================
module tb_mem_step_sequencer;

    localparam int          TO  = 8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        sys_clk = 1'b0;
    logic        sys_reset = 1'b0;
    logic        run = 1'b0;
    logic [31:0] progctr = '0;
    logic [31:0] memory_address = '0;
    logic [31:0] to_memory = '0;
    logic        memload_flag = 1'b0;
    logic        memstore_flag = 1'b0;
    logic [31:0] instruction;
    logic [31:0] from_memory;
    logic        cpu_step;
    logic        fault;
    logic        busy;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] exp_from = '0;

    mem_step_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_step_sequencer #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (TO),
        .NOP_INSTR(NOP)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_reset     (sys_reset),
        .run           (run),
        .progctr       (progctr),
        .memory_address(memory_address),
        .to_memory     (to_memory),
        .memload_flag  (memload_flag),
        .memstore_flag (memstore_flag),
        .instruction   (instruction),
        .from_memory   (from_memory),
        .cpu_step      (cpu_step),
        .fault         (fault),
        .busy          (busy),
        .mem           (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store, 3 = load+store flags (acts as store).
    // fw/dw: wait cycles before ack in the fetch/data access.
    task automatic run_instr(input logic [31:0] pc, input logic [31:0] da,
                             input logic [31:0] wd, input int kind,
                             input int fw, input int dw,
                             input logic [31:0] fdata, input logic [31:0] ddata,
                             input bit drop_run);
        int cyc = 0;
        int fn = 0;
        int dn = 0;
        int bad = 0;
        int exp_lat;
        bit fdone = 1'b0;
        bit stepped = 1'b0;
        bit is_mem;
        progctr        = pc;
        memory_address = da;
        to_memory      = wd;
        memload_flag   = (kind == 1) || (kind == 3);
        memstore_flag  = (kind == 2) || (kind == 3);
        is_mem         = (kind != 0);
        bus.mem_ack    = 1'b0;
        while (!stepped && cyc < 100) begin
            @(negedge sys_clk);
            cyc++;
            if (cpu_step) begin
                stepped = 1'b1;
                chk("busy_in_step", 32'(busy), 32'd1);
            end else if (bus.mem_req) begin
                if (!fdone) begin
                    fn++;
                    if (bus.mem_we !== 1'b0 || bus.mem_addr !== pc) bad++;
                    if (fn == fw + 1) begin
                        bus.mem_ack = 1'b1; bus.mem_rdata = fdata; fdone = 1'b1;
                    end else begin
                        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
                    end
                end else begin
                    dn++;
                    if (bus.mem_we !== memstore_flag || bus.mem_addr !== da ||
                        (memstore_flag && bus.mem_wdata !== wd)) bad++;
                    if (dn == dw + 1) begin
                        bus.mem_ack = 1'b1; bus.mem_rdata = ddata;
                    end else begin
                        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
                    end
                end
            end else begin
                if (drop_run && fdone) run = 1'b0;
                // Stray acks while no request is outstanding must be ignored.
                bus.mem_ack   = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
            end
        end
        exp_lat = 3 + (is_mem ? 1 + dw : 0) + fw;
        if (kind == 1) exp_from = ddata;
        chk("step_seen", 32'(stepped), 32'd1);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("fetch_cycles", 32'(fn), 32'(fw + 1));
        chk("data_cycles", 32'(dn), is_mem ? 32'(dw + 1) : 32'd0);
        chk("bus_fields", 32'(bad), 32'd0);
        chk("instruction", instruction, fdata);
        chk("from_memory", from_memory, exp_from);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int  viol;
        int  fn;
        bit  found;
        bit  fetched;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        repeat (3) @(negedge sys_clk);
        chk("rst_instruction", instruction, NOP);
        chk("rst_from_memory", from_memory, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_cpu_step", 32'(cpu_step), 32'd0);
        sys_reset = 1'b1;
        @(negedge sys_clk);
        chk("idle_no_req", 32'(bus.mem_req), 32'd0);
        run = 1'b1;

        run_instr(32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h00500093, 32'h0, 1'b0);
        run_instr(32'h4, 32'h100, $urandom, 1, 0, 2, 32'h00002083, 32'hDEADBEEF, 1'b0);
        run_instr(32'h8, 32'h200, 32'h12345678, 2, 1, 0, 32'h00002023, $urandom, 1'b0);
        run_instr(32'hC, $urandom, $urandom, 3, 0, 1, $urandom, $urandom, 1'b0);
        run_instr(32'h10, $urandom, $urandom, 0, TO, 0, $urandom, $urandom, 1'b0);
        run_instr(32'h14, $urandom, $urandom, 1, 0, TO, $urandom, $urandom, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_instr($urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      $urandom, $urandom, 1'b0);
        end

        run_instr($urandom, $urandom, $urandom, 0, 1, 0, $urandom, $urandom, 1'b1);
        viol = 0;
        repeat (6) begin
            @(negedge sys_clk);
            if (bus.mem_req || busy || cpu_step) viol++;
        end
        chk("run_drop_idle", 32'(viol), 32'd0);

        // Asynchronous reset while a load waits for its ack.
        progctr = 32'h40; memory_address = 32'h300; to_memory = $urandom;
        memload_flag = 1'b1; memstore_flag = 1'b0;
        bus.mem_ack = 1'b0; found = 1'b0; fetched = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge sys_clk);
            if (bus.mem_req && !fetched) begin
                bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A50001; fetched = 1'b1;
            end else if (bus.mem_req && fetched) begin
                found = 1'b1;
            end else begin
                bus.mem_ack = 1'b0;
            end
        end
        chk("data_reached", 32'(found), 32'd1);
        repeat (2) @(negedge sys_clk);
        chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
        sys_reset = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_instruction", instruction, NOP);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fault", 32'(fault), 32'd0);
        chk("mid_rst_from_memory", from_memory, 32'd0);
        exp_from = '0;
        run = 1'b0;
        memload_flag = 1'b0;
        @(negedge sys_clk);
        sys_reset = 1'b1;

        // Watchdog: fetch never acknowledged.
        @(negedge sys_clk);
        bus.mem_ack = 1'b0;
        run = 1'b1;
        fn = 0;
        for (int i = 0; i < 50 && !fault; i++) begin
            @(negedge sys_clk);
            if (!fault && bus.mem_req) fn++;
        end
        chk("wd_fault", 32'(fault), 32'd1);
        chk("wd_req_cycles", 32'(fn), 32'(TO + 1));
        chk("wd_mem_req", 32'(bus.mem_req), 32'd0);
        viol = 0;
        repeat (20) begin
            @(negedge sys_clk);
            bus.mem_ack = 1'($urandom_range(0, 1));
            if (bus.mem_req || cpu_step || busy || !fault) viol++;
        end
        chk("wd_stays_halted", 32'(viol), 32'd0);
        sys_reset = 1'b0;
        #1;
        chk("wd_reset_fault", 32'(fault), 32'd0);
        chk("wd_reset_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_step_sequencer.md
Name: mem_step_sequencer

Overview:
Multi-cycle sequencer that runs the single-cycle RV32I core against one shared single-port memory with variable latency and a req/ack handshake.
For each instruction it fetches at progctr and latches the instruction word. If the decoded instruction is a load or store, it performs the data access. It then pulses cpu_step for one cycle; cpu_step gates the core's PC and regfile update.
It sits between the cpu top and the memory, owns the only memory port, and has a watchdog that halts on a stuck access.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
TIMEOUT, 255, max wait cycles per access before fault; 0 disables the watchdog
NOP_INSTR, 32'h00000013, instruction register value at reset (addi x0,x0,0)

Ports:
sys_clk  in  1  system clock, rising edge
sys_reset  in  1  asynchronous, active-low reset
run  in  1  1 = execute; 0 = stop at the next instruction boundary
progctr  in  ADDR_W  core PC (fetch address)
memory_address  in  ADDR_W  core data address
to_memory  in  DATA_W  core store data
memload_flag  in  1  core decodes a load
memstore_flag  in  1  core decodes a store
instruction  out  DATA_W  latched instruction word to the core
from_memory  out  DATA_W  latched load data to the core
cpu_step  out  1  one-cycle commit enable for the core
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  access complete
fault  out  1  sticky watchdog fault
busy  out  1  state != IDLE and state != HALT

Behaviour:
- States: IDLE, FETCH, DECODE, DATA, STEP, HALT (registered).
- Reset (sys_reset=0, asynchronous):
  - State goes to IDLE.
  - instruction = NOP_INSTR; from_memory = 0; fault = 0; wait counter = 0.
  - cpu_step, mem_req and mem_we are 0 immediately, even mid-access.
- IDLE: all memory outputs 0. run=1 -> FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=progctr.
  - On mem_ack: instruction <= mem_rdata; go to DECODE.
- DECODE: one settle cycle so the core's flags follow the new instruction. memload_flag|memstore_flag -> DATA, else -> STEP.
- DATA:
  - mem_req=1, mem_we=memstore_flag, mem_addr=memory_address, mem_wdata=to_memory.
  - On mem_ack: if load, from_memory <= mem_rdata; go to STEP.
  - Stores leave from_memory unchanged.
- STEP: cpu_step=1 for exactly one cycle. Then run=1 -> FETCH, run=0 -> IDLE.
- HALT: fault=1, mem_req=0, cpu_step=0. Stays in HALT until reset; run is ignored.
- Handshake:
  - mem_* outputs are a combinational decode of the state plus the core signals.
  - The core does not advance outside STEP, so address and data are stable for the whole request.
  - Ack in the first request cycle is accepted (zero-wait).
  - mem_req drops in the cycle after ack. mem_ack outside FETCH/DATA is ignored.
  - memload_flag and memstore_flag both set: treated as a store.
- Latency (zero-wait memory): non-memory instruction 3 cycles (FETCH, DECODE, STEP); load/store 4 cycles. Each ack wait cycle adds 1.
- Watchdog:
  - The wait counter clears on entry to FETCH or DATA and increments each cycle without ack.
  - When the counter reaches TIMEOUT with no ack -> HALT (fault=1).
  - Ack in the same cycle as the limit wins: the access completes normally.
  - TIMEOUT=0: no timeout.
  - Counter width is clog2(TIMEOUT+1), saturating.
- run deasserted mid-instruction: the current instruction completes, including its cpu_step, then the FSM enters IDLE.

Test Plan:
- Reset mid-DATA: hold mem_ack=0 in DATA, drop sys_reset -> mem_req=0 same cycle; instruction=32'h00000013; busy=0; fault=0.
- ALU instruction, zero-wait: run=1, progctr=0, ack in the first FETCH cycle with mem_rdata=32'h00500093 -> instruction=32'h00500093; cpu_step high exactly in cycle 3; no DATA request.
- Load, 2-wait: memload_flag=1, memory_address=32'h100, ack on the 3rd DATA cycle with mem_rdata=32'hDEADBEEF -> mem_addr=32'h100 and mem_we=0 held 3 cycles; from_memory=32'hDEADBEEF; one cpu_step.
- Store: memstore_flag=1, memory_address=32'h200, to_memory=32'h12345678 -> mem_we=1, mem_wdata=32'h12345678; from_memory unchanged.
- Watchdog: TIMEOUT=8, never ack in FETCH -> fault=1 after 8 wait cycles; mem_req=0; no cpu_step. Still halted with run=1 until reset.
- run drop in DECODE: current instruction still steps once, then IDLE; no further mem_req.
